// File: rtl/relu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : relu_pkg
// Brief    : Shared constants, state encoding and helpers for the ReLU
//            stream-out block.
// Revision : 1.0
// ============================================================================
package relu_pkg;

  localparam int NUM_NEURONS = 4;
  localparam int NUM_LANES   = 4;
  localparam int FRAME_LEN   = NUM_NEURONS * NUM_LANES;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  localparam int IDX_W = clog2(FRAME_LEN);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/relu_4n_stream_out_act_requant.sv
`default_nettype none
// ============================================================================
// Module   : act_requant
// Brief    : Combinational arithmetic shift plus unsigned saturation.
// Revision : 1.0
// ============================================================================
module act_requant #(
  parameter int ACT_SIZE = 17,
  parameter int OUT_SIZE = 8,
  parameter int SHIFT    = 8
) (
  input  logic signed [ACT_SIZE-1:0] i_act,
  output logic        [OUT_SIZE-1:0] o_q
);

  logic signed [ACT_SIZE-1:0] w_shr;

  assign w_shr = i_act >>> SHIFT;

  // Any set bit above the output width (on a non-negative value) means overflow.
  always_comb begin
    o_q = w_shr[OUT_SIZE-1:0];
    if (w_shr[ACT_SIZE-1]) begin
      o_q = '0;
    end else if (|w_shr[ACT_SIZE-2:OUT_SIZE]) begin
      o_q = '1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/relu_4n_stream_out.sv
`default_nettype none
// ============================================================================
// Module   : relu_4n_stream_out
// Brief    : Captures a 16-activation ReLU frame and streams it out one
//            requantised element per valid/ready beat.
// Revision : 1.0
// ============================================================================
module relu_4n_stream_out
  import relu_pkg::*;
#(
  parameter int ACT_SIZE = 17,
  parameter int OUT_SIZE = 8,
  parameter int SHIFT    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [ACT_SIZE-1:0] in0_n0,
  input  logic signed [ACT_SIZE-1:0] in1_n0,
  input  logic signed [ACT_SIZE-1:0] in2_n0,
  input  logic signed [ACT_SIZE-1:0] in3_n0,
  input  logic signed [ACT_SIZE-1:0] in0_n1,
  input  logic signed [ACT_SIZE-1:0] in1_n1,
  input  logic signed [ACT_SIZE-1:0] in2_n1,
  input  logic signed [ACT_SIZE-1:0] in3_n1,
  input  logic signed [ACT_SIZE-1:0] in0_n2,
  input  logic signed [ACT_SIZE-1:0] in1_n2,
  input  logic signed [ACT_SIZE-1:0] in2_n2,
  input  logic signed [ACT_SIZE-1:0] in3_n2,
  input  logic signed [ACT_SIZE-1:0] in0_n3,
  input  logic signed [ACT_SIZE-1:0] in1_n3,
  input  logic signed [ACT_SIZE-1:0] in2_n3,
  input  logic signed [ACT_SIZE-1:0] in3_n3,
  input  logic                       relu_ready,
  output logic        [OUT_SIZE-1:0] out_data,
  output logic        [IDX_W-1:0]    out_idx,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  logic signed [ACT_SIZE-1:0] w_in  [FRAME_LEN];
  logic signed [ACT_SIZE-1:0] r_buf [FRAME_LEN];

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               r_rdy_d;
  logic               r_ovr;
  logic               w_evt;
  logic               w_acc;
  logic               w_last;
  logic               w_load;
  logic               w_ovr_set;

  // Element index = 4*neuron + lane.
  assign w_in[0]  = in0_n0;  assign w_in[1]  = in1_n0;
  assign w_in[2]  = in2_n0;  assign w_in[3]  = in3_n0;
  assign w_in[4]  = in0_n1;  assign w_in[5]  = in1_n1;
  assign w_in[6]  = in2_n1;  assign w_in[7]  = in3_n1;
  assign w_in[8]  = in0_n2;  assign w_in[9]  = in1_n2;
  assign w_in[10] = in2_n2;  assign w_in[11] = in3_n2;
  assign w_in[12] = in0_n3;  assign w_in[13] = in1_n3;
  assign w_in[14] = in2_n3;  assign w_in[15] = in3_n3;

  assign w_evt  = relu_ready & ~r_rdy_d;
  assign w_acc  = (r_state == STREAM) & out_ready;
  assign w_last = (r_idx == IDX_W'(FRAME_LEN - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_evt) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (w_acc && w_last) begin
          w_idx_nxt = '0;
          if (w_evt) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          if (w_acc) begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
          w_ovr_set = w_evt;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_rdy_d <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_rdy_d <= relu_ready;
      r_ovr   <= w_ovr_set | (r_ovr & ~overrun_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FRAME_LEN; i++) r_buf[i] <= '0;
    end else if (w_load) begin
      for (int i = 0; i < FRAME_LEN; i++) r_buf[i] <= w_in[i];
    end
  end

  act_requant #(
    .ACT_SIZE (ACT_SIZE),
    .OUT_SIZE (OUT_SIZE),
    .SHIFT    (SHIFT)
  ) u_requant (
    .i_act (r_buf[r_idx]),
    .o_q   (out_data)
  );

  assign out_idx    = r_idx;
  assign out_valid  = (r_state == STREAM);
  assign busy       = (r_state == STREAM);
  assign out_last   = out_valid & w_last;
  assign frame_done = w_acc & w_last;
  assign overrun    = r_ovr;

endmodule
`default_nettype wire
